// File: rtl/nn_reg_pkg.sv
// Shared defaults and width helpers for the neural-network register banks.
package nn_reg_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  typedef logic [DW_DEF-1:0] word_t;

  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_cell.sv
// One bank entry: DW-wide register with async active-low reset, sync clear and load enable.
module reg_cell #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/reg_shift_bank.sv
// Register bank with shift-in, addressed load, registered random read and a saturating fill counter.
module reg_shift_bank
  import nn_reg_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = aw_of(DEPTH),
  localparam int CW    = cw_of(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift_en,
  input  logic [DW-1:0]       sin,
  input  logic                ld,
  input  logic [AW-1:0]       waddr,
  input  logic [DW-1:0]       wdata,
  input  logic [AW-1:0]       raddr,
  output logic [DW-1:0]       rdata,
  output logic [DW*DEPTH-1:0] bank,
  output logic [DW-1:0]       sout,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic                err
);

  logic [DW-1:0] e [DEPTH];

  logic [DW-1:0] rdata_reg, rdata_next;
  logic [CW-1:0] count_reg, count_next;
  logic          err_reg, err_next;

  // Shift takes every cell; a load only enables the addressed one.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      logic          cell_en;
      logic [DW-1:0] cell_d;
      logic [DW-1:0] shift_src;

      if (gi == 0) begin : g_head
        assign shift_src = sin;
      end else begin : g_body
        assign shift_src = e[gi-1];
      end

      assign cell_en = shift_en | (ld & (waddr == AW'(gi)));
      assign cell_d  = shift_en ? shift_src : wdata;

      reg_cell #(.DW(DW)) u_cell (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (cell_en),
        .d   (cell_d),
        .q   (e[gi])
      );

      assign bank[gi*DW +: DW] = e[gi];
    end
  endgenerate

  always_comb begin
    rdata_next = '0;
    if (!clr && (int'(raddr) < DEPTH)) begin
      rdata_next = e[raddr];
    end
  end

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (shift_en && (count_reg != CW'(DEPTH))) begin
      count_next = count_reg + 1'b1;
    end
  end

  // A load is lost either to a concurrent shift or to an address past the last entry.
  always_comb begin
    err_next = 1'b0;
    if (!clr && ld) begin
      err_next = shift_en || (int'(waddr) >= DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      rdata_reg <= rdata_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  assign rdata = rdata_reg;
  assign count = count_reg;
  assign err   = err_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign sout  = e[DEPTH-1];

endmodule

// File: tb/tb_reg_shift_bank.sv
// Directed checks of reg_shift_bank in a DEPTH=4 build and a DEPTH=3 build.
module tb_reg_shift_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=4 instance
  logic        a_clr = 0, a_shift_en = 0, a_ld = 0;
  logic [7:0]  a_sin = 0, a_wdata = 0;
  logic [1:0]  a_waddr = 0, a_raddr = 0;
  logic [7:0]  a_rdata, a_sout;
  logic [31:0] a_bank;
  logic [2:0]  a_count;
  logic        a_full, a_err;

  // DEPTH=3 instance
  logic        b_clr = 0, b_shift_en = 0, b_ld = 0;
  logic [7:0]  b_sin = 0, b_wdata = 0;
  logic [1:0]  b_waddr = 0, b_raddr = 0;
  logic [7:0]  b_rdata, b_sout;
  logic [23:0] b_bank;
  logic [1:0]  b_count;
  logic        b_full, b_err;

  reg_shift_bank #(.DW(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .shift_en(a_shift_en), .sin(a_sin),
    .ld(a_ld), .waddr(a_waddr), .wdata(a_wdata), .raddr(a_raddr),
    .rdata(a_rdata), .bank(a_bank), .sout(a_sout), .count(a_count),
    .full(a_full), .err(a_err)
  );

  reg_shift_bank #(.DW(8), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .shift_en(b_shift_en), .sin(b_sin),
    .ld(b_ld), .waddr(b_waddr), .wdata(b_wdata), .raddr(b_raddr),
    .rdata(b_rdata), .bank(b_bank), .sout(b_sout), .count(b_count),
    .full(b_full), .err(b_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_shift(input logic [7:0] v);
    a_shift_en = 1'b1;
    a_sin      = v;
    tick();
    a_shift_en = 1'b0;
  endtask

  task automatic b_shift(input logic [7:0] v);
    b_shift_en = 1'b1;
    b_sin      = v;
    tick();
    b_shift_en = 1'b0;
  endtask

  initial begin
    // reset held across edges
    tick();
    tick();
    check("rst_bank", a_bank, 32'h0);
    check("rst_rdata", a_rdata, 8'h00);
    check("rst_count", a_count, 3'd0);
    check("rst_full", a_full, 1'b0);
    check("rst_err", a_err, 1'b0);
    check("rst_sout", a_sout, 8'h00);
    rst = 1'b1;
    tick();
    check("idle_bank", a_bank, 32'h0);

    // fill the DEPTH=4 bank
    a_shift(8'h11);
    a_shift(8'h22);
    a_shift(8'h33);
    check("three_count", a_count, 3'd3);
    check("three_full", a_full, 1'b0);
    check("three_sout", a_sout, 8'h00);
    a_shift(8'h44);
    check("fill_bank", a_bank, 32'h11223344);
    check("fill_sout", a_sout, 8'h11);
    check("fill_count", a_count, 3'd4);
    check("fill_full", a_full, 1'b1);
    a_shift(8'h55);
    check("fifth_bank", a_bank, 32'h22334455);
    check("fifth_count", a_count, 3'd4);
    check("fifth_full", a_full, 1'b1);

    // load with same-cycle read of the same address
    a_ld = 1'b1; a_waddr = 2'd2; a_wdata = 8'hAB; a_raddr = 2'd2;
    tick();
    a_ld = 1'b0;
    check("ld_rdata_old", a_rdata, 8'h33);
    check("ld_bank", a_bank, 32'h22AB4455);
    check("ld_err", a_err, 1'b0);
    tick();
    check("ld_rdata_new", a_rdata, 8'hAB);
    check("ld_count", a_count, 3'd4);

    // load collides with shift
    a_shift_en = 1'b1; a_sin = 8'h77; a_ld = 1'b1; a_waddr = 2'd0; a_wdata = 8'hEE;
    tick();
    a_shift_en = 1'b0; a_ld = 1'b0;
    check("coll_bank", a_bank, 32'hAB445577);
    check("coll_err", a_err, 1'b1);
    check("coll_count", a_count, 3'd4);
    tick();
    check("coll_err_pulse", a_err, 1'b0);

    // clear beats shift and load while full
    a_raddr = 2'd3;
    a_clr = 1'b1; a_shift_en = 1'b1; a_sin = 8'h99; a_ld = 1'b1; a_waddr = 2'd1; a_wdata = 8'hCC;
    tick();
    a_clr = 1'b0; a_shift_en = 1'b0; a_ld = 1'b0;
    check("clr_bank", a_bank, 32'h0);
    check("clr_count", a_count, 3'd0);
    check("clr_full", a_full, 1'b0);
    check("clr_rdata", a_rdata, 8'h00);
    check("clr_err", a_err, 1'b0);

    // asynchronous reset mid-stream
    a_raddr = 2'd0;
    a_shift_en = 1'b1;
    a_sin = 8'h01;
    tick();
    a_sin = 8'h02;
    tick();
    check("mid_bank", a_bank, 32'h00000102);
    check("mid_count", a_count, 3'd2);
    check("mid_rdata", a_rdata, 8'h01);
    a_shift_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("async_bank", a_bank, 32'h0);
    check("async_count", a_count, 3'd0);
    check("async_rdata", a_rdata, 8'h00);
    tick();
    rst = 1'b1;
    tick();

    // DEPTH=3 build
    b_shift(8'h01);
    b_shift(8'h02);
    b_shift(8'h03);
    check("b3_full", b_full, 1'b1);
    b_shift(8'h04);
    check("b_sat_count", b_count, 2'd3);
    check("b_bank", b_bank, 24'h020304);
    check("b_sout", b_sout, 8'h02);
    b_ld = 1'b1; b_waddr = 2'd3; b_wdata = 8'hFF;
    tick();
    b_ld = 1'b0;
    check("b_bad_ld_err", b_err, 1'b1);
    check("b_bad_ld_bank", b_bank, 24'h020304);
    b_raddr = 2'd2;
    tick();
    check("b_err_pulse", b_err, 1'b0);
    check("b_rdata2", b_rdata, 8'h02);
    b_raddr = 2'd3;
    tick();
    check("b_rdata_oob", b_rdata, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_shift_bank.md
# reg_shift_bank

Parametrised register bank replacing the fixed-width single registers in the neural-network datapath. It holds DEPTH words of DW bits and supports two write modes: addressed parallel load for weights and serial shift-in for streaming neuron inputs. It provides a registered random-access read port, a flattened full-bank view for the MAC array, and a fill counter. A serial output allows banks to be chained.

## Interface
- DW, 8, word width in bits (≥1)
- DEPTH, 4, number of entries (≥2)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- CW, $clog2(DEPTH+1), fill-count width (derived)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of all entries, count and rdata
- shift_en  in  1  shift sin into entry 0
- sin  in  DW  serial input word
- ld  in  1  addressed load
- waddr  in  AW  load address
- wdata  in  DW  load data
- raddr  in  AW  read address
- rdata  out  DW  registered read data
- bank  out  DW*DEPTH  all entries, entry i at bits [i*DW +: DW]
- sout  out  DW  entry DEPTH-1 (oldest), combinational from state
- count  out  CW  number of words shifted in since last clear, saturating
- full  out  1  count == DEPTH
- err  out  1  one-cycle pulse on a dropped or illegal load

## Operation
- Entries e[0..DEPTH-1]. Per-edge priority: clr > shift_en > ld.
- clr: all e ← 0, count ← 0, rdata ← 0, err ← 0. shift_en and ld in the same cycle are ignored without an err pulse.
- shift_en (no clr): e[0] ← sin, e[i] ← e[i-1] for i ≥ 1. The old e[DEPTH-1] is discarded. count ← min(count+1, DEPTH).
- ld with shift_en (no clr): ld is dropped, err ← 1.
- ld alone: e[waddr] ← wdata. count is unchanged.
- ld alone with waddr ≥ DEPTH (only possible when DEPTH is not a power of two): no write, err ← 1.
- err is 0 in every other cycle.
- Read: rdata ← e[raddr] sampled before this edge's update, giving old-value read-during-write semantics. raddr ≥ DEPTH gives rdata ← 0. rdata updates every cycle; there is no enable.
- bank, sout and full are combinational decodes of registered state only. There is no input-to-output combinational path.
- Arithmetic: count is unsigned with CW bits and never wraps. Data passes through unmodified, with no sign handling.

## Timing
- Reset (rst = 0, asynchronous assert): all e = 0, rdata = 0, count = 0, full = 0, err = 0, hence bank = 0 and sout = 0.
- Release of rst takes effect at the first rising clk after deassertion. Deassertion is synchronised externally.
- Reset asserted mid-shift or mid-load aborts the operation. No partial update is retained.
- Write latency: 1 cycle. A value written at edge N appears on bank and sout after edge N.
- Read latency: 1 cycle from raddr to rdata. Reading an address written at the same edge returns the old value; the new value is returned one cycle later.
- full asserts in the cycle after the DEPTH-th shift and remains asserted while shifting continues. Only clr or rst deasserts it.
- Back-to-back shift_en every cycle is supported. A word inserted at edge N appears on sout after edge N+DEPTH-1.

## Structure
- Shared package nn_reg_pkg:
  - defaults for DW and DEPTH
  - localparam helpers for AW and CW
  - typedef for the bank word.
- One natural sub-module: reg_cell (DW-wide register with async active-low reset, sync clr, load enable and data mux). Instantiate DEPTH times in a generate loop; the shift/load mux selects each cell's input.
- Count, err and rdata logic live in the top level.

## Test plan
- Reset then idle, with DW=8 and DEPTH=4: bank=0, rdata=0, count=0, full=0, err=0. Assert rst mid-stream after two shifts: all outputs return to 0 immediately, without waiting for an edge.
- Shift 0x11, 0x22, 0x33, 0x44 on consecutive cycles:
  - bank = 0x11223344 (e[3]=0x11)
  - sout = 0x11
  - full = 1 after the fourth edge.
  - A fifth shift of 0x55 gives bank = 0x22334455 and count stays 4.
- ld waddr=2 wdata=0xAB with raddr=2 in the same cycle: rdata returns the old e[2], then 0xAB next cycle. count is unchanged.
- ld and shift_en together with sin=0x77: the shift occurs, the load is dropped, and err pulses for exactly one cycle.
- clr together with shift_en and ld while full: all entries 0, count=0, full=0, rdata=0, err=0.
- DEPTH=3 build:
  - ld waddr=3: no entry changes, err=1.
  - raddr=3: rdata=0.
  - count saturates at 3 after four shifts.
